// File: rtl/dpram_pkg.sv
// Shared definitions for the byte-enabled dual-port RAM: port FSM states,
// read-during-write mode selectors and the byte-lane rotation helper.
package dpram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RESP
  } port_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Bit distance between a request lane and the memory lane it lands on,
  // for a request that starts offset bytes into a word.
  function automatic int unsigned lane_shift(input int unsigned offset);
    return offset * 8;
  endfunction

endpackage

// File: rtl/dpram_port_ctrl.sv
// One RAM port: req/ack handshake, access FSM, word/offset split, range
// check, rotation between request lanes and memory lanes, and assembly of
// the registered read data from up to two word accesses.
// The lane rotation assumes DATA_W is at least 16 (two or more byte lanes).
module dpram_port_ctrl
  import dpram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 65536,
  parameter int IDX_W       = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ready,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata,
  output logic                ack,
  output logic                err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [IDX_W-1:0]    mem_idx,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int W     = DATA_W / 8;
  localparam int OFF_W = $clog2(W);

  port_state_t state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [W-1:0]      be_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              range_err;
  logic [OFF_W-1:0]  offset;
  logic [31:0]       off_w;
  int unsigned       shift;
  logic [IDX_W-1:0]  word_lo;
  logic [IDX_W-1:0]  word_hi;
  logic [W-1:0]      lo_region;
  logic [W-1:0]      be_rot;
  logic [DATA_W-1:0] keep_lo_bits;
  logic [DATA_W-1:0] wdata_rot;
  logic [DATA_W-1:0] rdata_rot;

  // The last byte touched must lie inside the memory; the extra top bit
  // keeps addresses near the top of the address space from wrapping.
  assign range_err = ({1'b0, addr} + (ADDR_W+1)'(W - 1)) >= (ADDR_W+1)'(DEPTH_BYTES);

  assign offset  = addr_q[OFF_W-1:0];
  assign off_w   = 32'(offset);
  assign shift   = lane_shift(off_w);
  assign word_lo = IDX_W'(addr_q >> OFF_W);
  assign word_hi = word_lo + IDX_W'(1);

  // Request lane i lives in memory lane (i + offset) mod W, so writes rotate
  // left and reads rotate right by the same amount.
  assign wdata_rot = DATA_W'(({wdata_q, wdata_q} << shift) >> DATA_W);
  assign be_rot    = W'(({be_q, be_q} << off_w) >> W);
  assign rdata_rot = DATA_W'({mem_rdata, mem_rdata} >> shift);

  // Split lanes between the low word (memory lanes >= offset, request lanes
  // below W - offset) and the high word (the remainder).
  always_comb begin
    lo_region    = '0;
    keep_lo_bits = '0;
    for (int j = 0; j < W; j++) begin
      lo_region[j]          = (32'(j) >= off_w);
      keep_lo_bits[j*8 +: 8] = {8{32'(j) < (32'(W) - off_w)}};
    end
  end

  // Access state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and the memory access presented in LO and HI.
  always_comb begin
    state_next = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_idx    = word_lo;
    mem_mask   = '0;
    mem_wdata  = wdata_rot;
    case (state)
      IDLE: begin
        if (req && ready) begin
          state_next = LO;
        end
      end
      LO: begin
        mem_en     = !err_q;
        mem_we     = we_q;
        mem_mask   = be_rot & lo_region;
        state_next = (err_q || (offset == '0)) ? RESP : HI;
      end
      HI: begin
        mem_en     = 1'b1;
        mem_we     = we_q;
        mem_idx    = word_hi;
        mem_mask   = be_rot & ~lo_region;
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the request on acceptance and build read data lane by lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && ready) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
            be_q    <= be;
            err_q   <= range_err;
            rdata_q <= '0;
          end
        end
        LO: begin
          if (!err_q && !we_q) begin
            rdata_q <= (rdata_q & ~keep_lo_bits) | (rdata_rot & keep_lo_bits);
          end
        end
        HI: begin
          if (!we_q) begin
            rdata_q <= (rdata_q & keep_lo_bits) | (rdata_rot & ~keep_lo_bits);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ack   = (state == RESP);
  assign err   = ack & err_q;
  assign rdata = rdata_q;

endmodule

// File: rtl/dpram_be_ctrl.sv
// Dual-port byte-addressed little-endian RAM with byte enables. Owns the
// storage, merges the two ports' writes (port 1 wins overlapping lanes),
// resolves read-during-write and sweeps the memory to zero after reset.
module dpram_be_ctrl
  import dpram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 65536,
  parameter int RDW_MODE    = 0
) (
  input  logic                m_clock,
  input  logic                p_reset,
  output logic                ready,
  input  logic                req1,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic [DATA_W/8-1:0] be1,
  output logic [DATA_W-1:0]   rdata1,
  output logic                ack1,
  output logic                err1,
  input  logic                req2,
  input  logic                we2,
  input  logic [ADDR_W-1:0]   addr2,
  input  logic [DATA_W-1:0]   wdata2,
  input  logic [DATA_W/8-1:0] be2,
  output logic [DATA_W-1:0]   rdata2,
  output logic                ack2,
  output logic                err2
);

  localparam int W      = DATA_W / 8;
  localparam int NWORDS = DEPTH_BYTES / W;
  localparam int IDX_W  = $clog2(NWORDS);

  logic [DATA_W-1:0] mem [NWORDS];
  logic [IDX_W-1:0]  clr_ptr;

  logic              p1_en, p1_we, p2_en, p2_we;
  logic [IDX_W-1:0]  p1_idx, p2_idx;
  logic [W-1:0]      p1_mask, p2_mask;
  logic [DATA_W-1:0] p1_wdata, p2_wdata;
  logic [DATA_W-1:0] p1_rdata, p2_rdata;

  dpram_port_ctrl #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH_BYTES(DEPTH_BYTES),
    .IDX_W      (IDX_W)
  ) u_port1 (
    .clk      (m_clock),
    .rst_n    (p_reset),
    .ready    (ready),
    .req      (req1),
    .we       (we1),
    .addr     (addr1),
    .wdata    (wdata1),
    .be       (be1),
    .rdata    (rdata1),
    .ack      (ack1),
    .err      (err1),
    .mem_en   (p1_en),
    .mem_we   (p1_we),
    .mem_idx  (p1_idx),
    .mem_mask (p1_mask),
    .mem_wdata(p1_wdata),
    .mem_rdata(p1_rdata)
  );

  dpram_port_ctrl #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH_BYTES(DEPTH_BYTES),
    .IDX_W      (IDX_W)
  ) u_port2 (
    .clk      (m_clock),
    .rst_n    (p_reset),
    .ready    (ready),
    .req      (req2),
    .we       (we2),
    .addr     (addr2),
    .wdata    (wdata2),
    .be       (be2),
    .rdata    (rdata2),
    .ack      (ack2),
    .err      (err2),
    .mem_en   (p2_en),
    .mem_we   (p2_we),
    .mem_idx  (p2_idx),
    .mem_mask (p2_mask),
    .mem_wdata(p2_wdata),
    .mem_rdata(p2_rdata)
  );

  // Word seen by each reader; in new-data mode the other port's same-cycle
  // write to the same word is forwarded lane by lane.
  always_comb begin
    p1_rdata = mem[p1_idx];
    p2_rdata = mem[p2_idx];
    if (RDW_MODE == RDW_NEW) begin
      if (p2_en && p2_we && (p2_idx == p1_idx)) begin
        for (int j = 0; j < W; j++) begin
          if (p2_mask[j]) begin
            p1_rdata[j*8 +: 8] = p2_wdata[j*8 +: 8];
          end
        end
      end
      if (p1_en && p1_we && (p1_idx == p2_idx)) begin
        for (int j = 0; j < W; j++) begin
          if (p1_mask[j]) begin
            p2_rdata[j*8 +: 8] = p1_wdata[j*8 +: 8];
          end
        end
      end
    end
  end

  // Post-reset sweep pointer; ready rises once the last word is cleared.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else if (!ready) begin
      if (clr_ptr == IDX_W'(NWORDS - 1)) begin
        ready <= 1'b1;
      end else begin
        clr_ptr <= clr_ptr + IDX_W'(1);
      end
    end
  end

  // Storage: zero one word per cycle while sweeping, otherwise apply port 2
  // then port 1 so port 1 takes any lane both ports write.
  always_ff @(posedge m_clock) begin
    if (!ready) begin
      mem[clr_ptr] <= '0;
    end else begin
      if (p2_en && p2_we) begin
        for (int j = 0; j < W; j++) begin
          if (p2_mask[j]) begin
            mem[p2_idx][j*8 +: 8] <= p2_wdata[j*8 +: 8];
          end
        end
      end
      if (p1_en && p1_we) begin
        for (int j = 0; j < W; j++) begin
          if (p1_mask[j]) begin
            mem[p1_idx][j*8 +: 8] <= p1_wdata[j*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: doc/dpram_be_ctrl.md
Name: dpram_be_ctrl

Overview:
Parametrised dual-port, byte-addressed, little-endian RAM. Successor to the flat dual-port byte RAM.
- Adds per-port req/ack handshake, byte enables and registered reads.
- Handles misaligned accesses in two cycles; rejects out-of-range accesses; clears memory after reset.
- Sits between two bus masters (e.g. instruction fetch on port 1, load/store on port 2) and shared local memory.

Parameters:
- DATA_W, 32, word width in bits; multiple of 8, power of two.
- ADDR_W, 32, byte-address width.
- DEPTH_BYTES, 65536, memory size in bytes; multiple of DATA_W/8.
- RDW_MODE, 0, read-during-write to the same word in the same cycle: 0 = old data, 1 = new data.

Ports:
- m_clock  in  1  single clock; all logic on rising edge.
- p_reset  in  1  asynchronous, active-low reset (asserted at 0).
- ready  out  1  high once post-reset clear is complete.
- req1/req2  in  1  request; held high until ack.
- we1/we2  in  1  1 = write, 0 = read; stable while req is high.
- addr1/addr2  in  ADDR_W  byte address; need not be aligned.
- wdata1/wdata2  in  DATA_W  write data; byte 0 = bits 7:0.
- be1/be2  in  DATA_W/8  byte enables, relative to addr.
- rdata1/rdata2  out  DATA_W  read data; valid in the ack cycle.
- ack1/ack2  out  1  one-cycle completion pulse.
- err1/err2  out  1  valid with ack; out-of-range access.

Behaviour:
- Reset asserted:
  - ready, ack*, err* = 0; rdata* = 0.
  - Both port FSMs go to IDLE; clear pointer = 0.
  - Any in-flight access is aborted with no ack. A partial misaligned write may leave the low word written; the sweep clears it.
- Clear sweep (after reset release):
  - One word per cycle is written to 0, from index 0 up to DEPTH_BYTES/(DATA_W/8)-1.
  - ready rises the cycle after the last word is cleared.
  - req is ignored while ready = 0.
- Address split: W = DATA_W/8; word index = addr / W; offset = addr % W. Access covers bytes addr..addr+W-1, lane i active iff be[i].
- Out of range: if addr+W-1 >= DEPTH_BYTES → ack the next cycle with err = 1, rdata = 0, no write. This includes the HI word of a misaligned access; there is no wrap-around.
- Port FSM states: IDLE, LO, HI, RESP.
  - IDLE: enters LO when req and ready.
  - LO: accesses word k. Goes to RESP if offset = 0 or err, otherwise to HI.
  - HI: accesses word k+1.
  - RESP: ack = 1, then back to IDLE.
  - A new request is sampled no earlier than the cycle after ack.
  - Latency from req sampled: aligned = ack 2 cycles after sampling (LO, RESP); misaligned = 3 cycles.
- Reads are registered: lanes are assembled from LO/HI word reads into rdata. Disabled lanes return the memory contents, not 0.
- Writes: only lanes with be = 1 are modified. be = 0 gives a legal no-op write, acked normally.
- Simultaneous writes to the same word: port 1 wins on overlapping lanes; non-overlapping lanes from both ports are applied.
- Simultaneous read on one port and write on the other to the same word: the read returns data per RDW_MODE, byte-lane exact.
- Ports are otherwise fully independent; no stalls.
- err and ack deassert the cycle after RESP.

Decomposition:
- dpram_pkg holds:
  - FSM state enum (IDLE/LO/HI/RESP);
  - RDW_OLD/RDW_NEW constants;
  - function lane_shift(offset) for byte rotation between request lanes and memory lanes.
- Sub-module dpram_port_ctrl: handshake, FSM, address split, range check, lane rotation and rdata assembly. Instantiated twice.
- The top level owns the storage array, the write merge/priority logic and the clear sweep.

Test Plan:
- Reset then idle (DEPTH_BYTES = 64, W = 4) → ready rises after 16 cycles; a read at addr 0x3C returns 0x00000000, err = 0.
- Port 1: write 0x11223344 at 0x10 with be = 0xF, then read 0x10 → ack 2 cycles after each req, rdata = 0x11223344.
- Misaligned: write 0xAABBCCDD at 0x0E, be = 0xF → 3-cycle ack; a read of 0x0C returns 0xCCDDxxxx and a read of 0x10 returns 0xxxxxAABB. A read of 0x3E gives err = 1, rdata = 0.
- Collision: same cycle, port 1 writes 0x000000FF be = 0x1 and port 2 writes 0x12345678 be = 0x3, both at 0x20 → the word reads 0x000056FF.
- RDW: port 1 writes 0xDEADBEEF at 0x30 while port 2 reads 0x30 (old value 0) → rdata2 = 0 with RDW_MODE = 0, 0xDEADBEEF with RDW_MODE = 1.
- Reset pulse mid misaligned write (in HI) → no ack; sweep reruns; after ready, both words read 0.
